// File: rtl/alu_nibble_seq_pkg.sv
// Shared types and widths for the nibble-serial ALU sequencer.
package alu_seq_pkg;
  localparam int NIBBLE_W = 4;
  localparam int SEL_W    = 4;
  localparam int MODE_W   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_nibble_seq_if.sv
// Control-path request/result bus plus the nibble-wide link to the external alu.
// Optional abort input is present when ALU_NIBBLE_SEQ_ABORT_EN is defined.
interface alu_nibble_seq_if #(parameter int NIBBLES = 4);
  import alu_seq_pkg::*;
  localparam int W = NIBBLE_W * NIBBLES;

  logic                start;
  logic [W-1:0]        op_a;
  logic [W-1:0]        op_b;
  logic [SEL_W-1:0]    op_s;
  logic [MODE_W-1:0]   op_m;
  logic                op_cin;
`ifdef ALU_NIBBLE_SEQ_ABORT_EN
  logic                abort;
`endif
  logic                busy;
  logic                done;
  logic [W-1:0]        result;
  logic                cout;
  logic                eqv;

  logic [NIBBLE_W-1:0] alu_a;
  logic [NIBBLE_W-1:0] alu_b;
  logic [SEL_W-1:0]    alu_s;
  logic [MODE_W-1:0]   alu_m;
  logic                alu_cin;
  logic [NIBBLE_W-1:0] alu_f;
  logic                alu_cout;
  logic                alu_eqv;

  // master: control path plus the alu instance; slave: the sequencer
  modport master (
    output start, op_a, op_b, op_s, op_m, op_cin,
`ifdef ALU_NIBBLE_SEQ_ABORT_EN
    output abort,
`endif
    input  busy, done, result, cout, eqv,
    input  alu_a, alu_b, alu_s, alu_m, alu_cin,
    output alu_f, alu_cout, alu_eqv
  );

  modport slave (
    input  start, op_a, op_b, op_s, op_m, op_cin,
`ifdef ALU_NIBBLE_SEQ_ABORT_EN
    input  abort,
`endif
    output busy, done, result, cout, eqv,
    output alu_a, alu_b, alu_s, alu_m, alu_cin,
    input  alu_f, alu_cout, alu_eqv
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Drives a 4-bit 74181-style alu one nibble per cycle, LSB first, chaining carry.
// Define ALU_NIBBLE_SEQ_ABORT_EN to add an abort input that cancels a running op.
import alu_seq_pkg::*;

module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             rst,
  alu_nibble_seq_if.slave bus
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [W-1:0]        r_a, r_b, r_shadow, r_result;
  logic [SEL_W-1:0]    r_s;
  logic [MODE_W-1:0]   r_m;
  logic                r_carry, r_eqacc, r_cout, r_eqv;
  logic                w_last, w_abort, w_run;
  logic [W-1:0]        w_shadow_nxt;

  assign w_run  = (r_state == ST_RUN);
  assign w_last = (r_idx == LAST);

`ifdef ALU_NIBBLE_SEQ_ABORT_EN
  assign w_abort = w_run & bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_abort)     w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Final nibble merged in so the commit edge sees the complete result.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[NIBBLE_W*r_idx +: NIBBLE_W] = bus.alu_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_m      <= '0;
      r_carry  <= 1'b0;
      r_eqacc  <= 1'b0;
      r_shadow <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_eqv    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.op_a;
            r_b     <= bus.op_b;
            r_s     <= bus.op_s;
            r_m     <= bus.op_m;
            r_carry <= bus.op_cin;
            r_eqacc <= 1'b1;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_idx <= '0;
          end else begin
            r_shadow <= w_shadow_nxt;
            r_carry  <= bus.alu_cout;
            r_eqacc  <= r_eqacc & bus.alu_eqv;
            if (w_last) begin
              r_result <= w_shadow_nxt;
              r_cout   <= bus.alu_cout;
              r_eqv    <= r_eqacc & bus.alu_eqv;
              r_idx    <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = w_run;
  assign bus.done    = (r_state == ST_DONE);
  assign bus.result  = r_result;
  assign bus.cout    = r_cout;
  assign bus.eqv     = r_eqv;

  // alu link is quiet outside RUN
  assign bus.alu_a   = w_run ? r_a[NIBBLE_W*r_idx +: NIBBLE_W] : '0;
  assign bus.alu_b   = w_run ? r_b[NIBBLE_W*r_idx +: NIBBLE_W] : '0;
  assign bus.alu_s   = w_run ? r_s : '0;
  assign bus.alu_m   = w_run ? r_m : '0;
  assign bus.alu_cin = w_run & r_carry;
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with a behavioural adder standing in for the alu.
// Abort scenario is compiled in when ALU_NIBBLE_SEQ_ABORT_EN is defined.
module tb_alu_nibble_seq;
  localparam int NIBBLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_nibble_seq_if #(.NIBBLES(NIBBLES)) bus ();

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // alu model: f = a + b + cin, active-high carry, eqv when f is all ones
  logic [4:0] w_sum;
  assign w_sum        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_cin};
  assign bus.alu_f    = w_sum[3:0];
  assign bus.alu_cout = w_sum[4];
  assign bus.alu_eqv  = (w_sum[3:0] == 4'hF);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and check the whole sequence; returns the observed alu_cin pattern.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_res,
                        input logic exp_cout, input logic exp_eqv,
                        output logic [3:0] cin_seq);
    bus.op_a = a; bus.op_b = b; bus.op_cin = cin; bus.op_s = 4'h9; bus.op_m = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cin_seq = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      cin_seq[k] = bus.alu_cin;
      tick();
    end
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_res"},  {16'd0, bus.result}, {16'd0, exp_res});
    chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, exp_cout});
    chk({tag, "_eqv"},  {31'd0, bus.eqv}, {31'd0, exp_eqv});
    tick();
    chk({tag, "_idle"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] cseq;
    logic [17:0] done_mask;
    int n_done;

    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_s = '0; bus.op_m = '0;
    bus.op_cin = 1'b0;
`ifdef ALU_NIBBLE_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk("rst_flags", {29'd0, bus.busy, bus.done, bus.cout}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    chk("rst_eqv", {31'd0, bus.eqv}, 32'd0);
    chk("rst_alu", {18'd0, bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_cin}, 32'd0);

    run_op("add", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, cseq);
    chk("add_cin_seq", {28'd0, cseq}, 32'b1110);
    run_op("ovf", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, cseq);
    run_op("eq1", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, cseq);
    run_op("eq0", 16'hFFFE, 16'h0000, 1'b0, 16'hFFFE, 1'b0, 1'b0, cseq);
    run_op("cin1", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, cseq);
    chk("cin1_seq", {28'd0, cseq}, 32'b0001);

    // start held high: accepts at T0, T0+6, T0+12 -> done at 5, 11, 17
    bus.op_a = 16'h00FF; bus.op_b = 16'h0F00; bus.op_cin = 1'b0;
    bus.start = 1'b1;
    done_mask = '0;
    n_done = 0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (bus.done) begin
        done_mask[c] = 1'b1;
        n_done++;
      end
    end
    bus.start = 1'b0;
    chk("hold_done_cnt", n_done, 32'd3);
    chk("hold_done_pos", {14'd0, done_mask}, 32'h00020820);
    chk("hold_result", {16'd0, bus.result}, 32'h00000FFF);
    tick();
    chk("hold_no_queue", {30'd0, bus.busy, bus.done}, 32'd0);
    tick();
    chk("hold_stay_idle", {31'd0, bus.busy}, 32'd0);

    // reset with idx=2
    bus.op_a = 16'h1111; bus.op_b = 16'h2222; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("mid_alu_a_idx2", {28'd0, bus.alu_a}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_flags", {29'd0, bus.busy, bus.done, bus.cout}, 32'd0);
    chk("mid_rst_result", {15'd0, bus.eqv, bus.result}, 32'd0);
    chk("mid_rst_alu", {27'd0, bus.alu_a, bus.alu_cin}, 32'd0);
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.done) n_done++;
    end
    chk("mid_rst_no_done", n_done, 32'd0);

`ifdef ALU_NIBBLE_SEQ_ABORT_EN
    run_op("pre_abort", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, cseq);
    bus.op_a = 16'h1234; bus.op_b = 16'h0000; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done) n_done++;
      tick();
    end
    chk("abort_no_done", n_done, 32'd0);
    chk("abort_keep_res", {14'd0, bus.cout, bus.eqv, bus.result}, 32'h0001FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Nibble-serial sequencer between the control path and the 4-bit 74181-style `alu`. It latches a wide operation (A, B, select, mode, carry-in) and drives the `alu` one nibble per cycle, LSB first. It chains the `alu` carry-out into the next nibble's carry-in and collects F and A=B into a wide result with final carry and equality flags. The `alu` instance stays outside this block, wired to the `alu_*` ports.

## Interface
- `NIBBLES`, 4: number of 4-bit slices. Operand width W = 4*NIBBLES, NIBBLES >= 1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; accepted only in IDLE.
- `op_a`, `op_b` in W: operands; sampled on accept.
- `op_s` in 4: `alu` function select; sampled on accept.
- `op_m` in 1: `alu` mode (logic/arith); sampled on accept.
- `op_cin` in 1: carry-in for nibble 0; sampled on accept.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse, high in DONE.
- `result` out W: committed F; holds until the next commit.
- `cout` out 1: `alu_cout` of the last nibble; committed with `result`.
- `eqv` out 1: AND of `alu_eqv` over all nibbles; committed with `result`.
- `alu_a`, `alu_b` out 4: current nibble of the latched A and B.
- `alu_s` out 4, `alu_m` out 1: latched select and mode.
- `alu_cin` out 1: carry into the current nibble.
- `alu_f` in 4, `alu_cout` in 1, `alu_eqv` in 1: combinational `alu` results for the current nibble.

## Operation
- States: IDLE, RUN, DONE. Nibble index `idx`, 0..NIBBLES-1.
- IDLE:
  - `start`=1 latches the op fields, sets `idx`=0, sets carry register to `op_cin`, sets eqv accumulator to 1, and goes to RUN.
  - All `alu_*` outputs drive 0.
- RUN, each cycle:
  - Drive `alu_a`=A[4*idx+:4], `alu_b`=B[4*idx+:4], `alu_cin`=carry register.
  - At the clock edge: shadow[4*idx+:4] <= `alu_f`; carry register <= `alu_cout`; eqv accumulator <= accumulator & `alu_eqv`.
  - If `idx`=NIBBLES-1: go to DONE. Otherwise `idx`++.
- DONE:
  - `result`, `cout`, `eqv` take the shadow, carry register and eqv accumulator at this state's entry edge, so they are visible while `done`=1.
  - Return to IDLE next cycle.
- Carry is opaque. No inversion is applied, so the `alu`'s carry polarity passes through unchanged. Carry is chained in logic mode too.
- `start` in RUN or DONE is ignored and is not queued.
- `rst` is synchronous and wins over every other event. State goes to IDLE, `idx`=0, and all outputs go to 0, including `result`, `cout`, `eqv`, `busy` and `done`. A reset mid-RUN discards the operation and produces no `done`.

## Timing
- Accept edge is T0.
- RUN occupies cycles T0+1 .. T0+NIBBLES.
- `done`=1 in cycle T0+NIBBLES+1; `result` is valid from that cycle onward.
- Earliest next accept is T0+NIBBLES+2, so throughput is one op per NIBBLES+2 cycles.
- The `alu` path is combinational within one cycle: `alu_*` outputs are registered-state driven and `alu_f` is captured at the same edge.

## Configuration
- `ALU_NIBBLE_SEQ_ABORT_EN` defined:
  - Adds an `abort` input (1 bit).
  - `abort`=1 in RUN returns to IDLE next cycle with no `done`, leaving `result`, `cout` and `eqv` unchanged.
  - `abort` in IDLE or DONE has no effect.
  - `abort` and `rst` together: reset wins.
- `ALU_NIBBLE_SEQ_ABORT_EN` undefined: no `abort` port and no abort logic.

## Structure
- Package `alu_seq_pkg` holds:
  - the state encoding (IDLE, RUN, DONE);
  - the constant `NIBBLE_W`=4;
  - the op-field widths (select 4, mode 1).
- Single flat module, no sub-module. The `alu` is instantiated by the integrator next to this block.

## Test plan
The bench uses NIBBLES=4 and a behavioural `alu` model: f=a+b+cin, cout=active-high carry, eqv=(f==4'hF).
- Reset: `rst` high 2 cycles -> `busy`, `done`, `result`, `cout`, `eqv` and all `alu_*` outputs = 0.
- Add across nibbles: A=16'h0FFF, B=16'h0001, cin=0 -> `alu_cin` sequence 0,1,1,1; `done` at T0+5; `result`=16'h1000, `cout`=0, `eqv`=0.
- Overflow: A=16'hFFFF, B=16'h0001, cin=0 -> `result`=16'h0000, `cout`=1.
- Equality:
  - A=16'hFFFF, B=0, cin=0 -> `eqv`=1.
  - Then A=16'hFFFE, B=0, cin=0 -> `eqv`=0.
- Start handling: `start` held high continuously -> accepts only at T0, T0+6, T0+12; exactly one `done` per op.
- Reset at `idx`=2 -> IDLE next cycle, no `done`, outputs 0. With `ALU_NIBBLE_SEQ_ABORT_EN`, `abort` at `idx`=2 -> no `done` and previous `result` retained.
